// File: rtl/wbubus_watchdog.sv
`default_nettype none
// wbubus_watchdog: Wishbone pass-through with outstanding-request tracking,
// inactivity timeout, synthetic error return and hard abort until master drops cyc.
module wbubus_watchdog #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int LGWATCHDOG   = 19,
  parameter int LGMAXPENDING = 4,
  parameter int LGTOCOUNT    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_mst_cyc,
  input  logic                  i_mst_stb,
  input  logic                  i_mst_we,
  input  logic [AW-1:0]         i_mst_addr,
  input  logic [DW-1:0]         i_mst_data,
  output logic                  o_mst_ack,
  output logic                  o_mst_stall,
  output logic                  o_mst_err,
  output logic [DW-1:0]         o_mst_data,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [AW-1:0]         o_wb_addr,
  output logic [DW-1:0]         o_wb_data,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_err,
  input  logic [DW-1:0]         i_wb_data,
  output logic                  o_timeout,
  output logic [LGMAXPENDING:0] o_pending,
  output logic [LGTOCOUNT-1:0]  o_timeout_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;

  localparam logic [LGMAXPENDING:0] MAX_PENDING = {1'b1, {LGMAXPENDING{1'b0}}};

  logic [1:0]              state;
  logic [LGMAXPENDING:0]   pending;
  logic [LGWATCHDOG-1:0]   timer;
  logic [LGTOCOUNT-1:0]    to_count;
  logic                    err_r;
  logic                    timeout_r;

  logic full;
  logic accept;
  logic resp;
  logic timer_clr;
  logic fire;

  // Reset gates the downstream cycle immediately so nothing leaks out mid-reset.
  assign o_wb_cyc  = i_mst_cyc && (state != ABORT) && !i_rst;
  assign full      = (pending == MAX_PENDING);
  assign o_wb_stb  = i_mst_stb && o_wb_cyc && !full;
  assign o_wb_we   = i_mst_we;
  assign o_wb_addr = i_mst_addr;
  assign o_wb_data = i_mst_data;
  assign o_mst_data = i_wb_data;

  assign o_mst_stall = i_wb_stall || full || (state == ABORT);
  assign accept      = o_wb_stb && !i_wb_stall;
  assign resp        = o_wb_cyc && (i_wb_ack || i_wb_err);
  assign o_mst_ack   = i_wb_ack && o_wb_cyc;
  assign o_mst_err   = (i_wb_err && o_wb_cyc) || err_r;

  assign timer_clr = (state != BUSY) || (pending == '0) || accept || resp;
  // A master dropping cyc in the same cycle takes precedence over the timeout.
  assign fire      = !timer_clr && (&timer) && i_mst_cyc;

  assign o_timeout       = timeout_r;
  assign o_pending       = pending;
  assign o_timeout_count = to_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      pending   <= '0;
      timer     <= '0;
      to_count  <= '0;
      err_r     <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      err_r     <= fire;
      timeout_r <= fire;

      case (state)
        IDLE:    if (i_mst_cyc) state <= BUSY;
        BUSY:    if (!i_mst_cyc) state <= IDLE;
                 else if (fire) state <= ABORT;
        ABORT:   if (!i_mst_cyc) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (!o_wb_cyc || i_wb_err)
        pending <= '0;
      else if (accept && !i_wb_ack)
        pending <= pending + 1'b1;
      else if (i_wb_ack && !accept && (pending != '0))
        pending <= pending - 1'b1;

      if (timer_clr || fire)
        timer <= '0;
      else
        timer <= timer + 1'b1;

      if (fire && !(&to_count))
        to_count <= to_count + 1'b1;
    end
  end

endmodule
`default_nettype wire
